// File: rtl/lq_issue_stage_if.sv
// lq_issue_stage_if
//   Data-memory load request bus with a valid/ready handshake.
//   master : drives req_valid/req_addr/req_id/req_fn3, samples req_ready
//   slave  : samples the request fields, drives req_ready
// Parameters: ADDR_W (address width), ID_W (load ID width).
interface lq_issue_stage_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 3
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [ID_W-1:0]   req_id;
    logic [2:0]        req_fn3;

    modport master (
        output req_valid,
        output req_addr,
        output req_id,
        output req_fn3,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_id,
        input  req_fn3,
        output req_ready
    );
endinterface

// File: rtl/lq_issue_stage.sv
// lq_issue_stage
//   Issues the load-queue FIFO head into a registered memory request stage once
//   every older store it depends on has committed, while capping the number of
//   loads accepted by memory but not yet acknowledged. A flush drains the FIFO
//   one entry per cycle and drops the held request.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   lq_valid/lq_addr/lq_id/lq_fn3/lq_store_mask   FIFO head entry
//   lq_pop            pop strobe back to the FIFO
//   sq_pending        store-queue entries not yet committed
//   flush             discard held and queued loads
//   req (master)      memory request bus (req_valid/ready/addr/id/fn3)
//   resp_ack          one outstanding load completed
//   outstanding       loads accepted by memory, not yet acknowledged
//   idle              nothing held, nothing outstanding, FIFO head empty
// Optional (macro LQ_ISSUE_STALL_CNT_EN):
//   stall_cycles      saturating count of cycles the head waited
//   dep_stall         head is blocked by an uncommitted older store
module lq_issue_stage #(
    parameter int ADDR_W          = 32,
    parameter int ID_W            = 3,
    parameter int SQ_DEPTH        = 4,
    parameter int MAX_OUTSTANDING = 4,
    localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lq_valid,
    input  logic [ADDR_W-1:0]   lq_addr,
    input  logic [ID_W-1:0]     lq_id,
    input  logic [2:0]          lq_fn3,
    input  logic [SQ_DEPTH-1:0] lq_store_mask,
    output logic                lq_pop,
    input  logic [SQ_DEPTH-1:0] sq_pending,
    input  logic                flush,
    lq_issue_stage_if.master    req,
    input  logic                resp_ack,
    output logic [CNT_W-1:0]    outstanding,
`ifdef LQ_ISSUE_STALL_CNT_EN
    output logic [15:0]         stall_cycles,
    output logic                dep_stall,
`endif
    output logic                idle
);

    localparam logic [CNT_W:0] MAX_EXT = (CNT_W + 1)'(MAX_OUTSTANDING);

    logic              hold_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic [ID_W-1:0]   hold_id;
    logic [2:0]        hold_fn3;
    logic [CNT_W-1:0]  out_cnt;

    logic              deps_ok;
    logic              slot_free;
    logic              credit_ok;
    logic              handshake;
    logic [CNT_W:0]    in_flight;

    // Credit looks only at registered state: an ack this cycle frees a credit
    // from the next cycle on.
    always_comb begin
        deps_ok   = ~|(lq_store_mask & sq_pending);
        handshake = hold_valid & req.req_ready;
        slot_free = ~hold_valid | handshake;
        in_flight = {1'b0, out_cnt} + {{CNT_W{1'b0}}, hold_valid};
        credit_ok = in_flight < MAX_EXT;
        lq_pop    = 1'b0;
        if (!rst) begin
            if (flush)
                lq_pop = lq_valid;
            else
                lq_pop = lq_valid & deps_ok & slot_free & credit_ok;
        end
    end

    // Request register. Entries popped during a flush are discarded, not loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_id    <= '0;
            hold_fn3   <= '0;
        end else if (flush) begin
            hold_valid <= 1'b0;
        end else if (lq_pop) begin
            hold_valid <= 1'b1;
            hold_addr  <= lq_addr;
            hold_id    <= lq_id;
            hold_fn3   <= lq_fn3;
        end else if (handshake) begin
            hold_valid <= 1'b0;
        end
    end

    // A handshake in a flush cycle still counts as issued.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_cnt <= '0;
        end else begin
            case ({handshake, resp_ack})
                2'b10:   out_cnt <= out_cnt + CNT_W'(1);
                2'b01:   out_cnt <= out_cnt - CNT_W'(1);
                default: out_cnt <= out_cnt;
            endcase
        end
    end

    assign req.req_valid = hold_valid;
    assign req.req_addr  = hold_addr;
    assign req.req_id    = hold_id;
    assign req.req_fn3   = hold_fn3;
    assign outstanding   = out_cnt;
    assign idle          = ~hold_valid & (out_cnt == '0) & ~lq_valid;

`ifdef LQ_ISSUE_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk) begin
        if (rst)
            stall_q <= '0;
        else if (lq_valid && !flush && !lq_pop && stall_q != '1)
            stall_q <= stall_q + 16'd1;
    end

    assign stall_cycles = stall_q;
    assign dep_stall    = lq_valid & ~deps_ok;
`endif

    a_pop_needs_valid: assert property (@(posedge clk) lq_pop |-> lq_valid);

    a_ack_legal: assert property (@(posedge clk) disable iff (rst)
        resp_ack |-> (out_cnt != '0));

    a_cnt_cap: assert property (@(posedge clk) disable iff (rst)
        {1'b0, out_cnt} <= MAX_EXT);

    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (hold_valid && !req.req_ready) |=>
            ($stable(hold_addr) && $stable(hold_id) && $stable(hold_fn3)));

endmodule

// File: tb/tb_lq_issue_stage.sv
// tb_lq_issue_stage
//   Randomized phases drive a FIFO model into lq_issue_stage. A reference model
//   (FIFO queue, held-slot flag, outstanding count) predicts lq_pop, req_valid,
//   outstanding and idle each cycle and pushes each expected request into a
//   scoreboard queue; a monitor pops and compares on every bus handshake.
module tb_lq_issue_stage;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 3;
    localparam int SQ     = 4;
    localparam int MAX    = 4;
    localparam int CNT_W  = $clog2(MAX + 1);

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic [2:0]        fn3;
        logic [SQ-1:0]     mask;
    } entry_t;

    typedef struct {
        int len;
        int p_ready;
        int p_ack;
        int p_flush;
        int p_dep;
        int p_rst;
        int p_push;
    } phase_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              lq_valid;
    logic [ADDR_W-1:0] lq_addr;
    logic [ID_W-1:0]   lq_id;
    logic [2:0]        lq_fn3;
    logic [SQ-1:0]     lq_store_mask;
    logic              lq_pop;
    logic [SQ-1:0]     sq_pending;
    logic              flush;
    logic              resp_ack;
    logic [CNT_W-1:0]  outstanding;
    logic              idle;
`ifdef LQ_ISSUE_STALL_CNT_EN
    logic [15:0]       stall_cycles;
    logic              dep_stall;
    int unsigned       m_stall;
`endif

    int total = 0;
    int bad   = 0;

    entry_t fifo[$];
    entry_t exp_req[$];
    bit     slot_full;
    int     m_out;

    lq_issue_stage_if #(.ADDR_W(ADDR_W), .ID_W(ID_W)) bus ();

    lq_issue_stage #(
        .ADDR_W(ADDR_W), .ID_W(ID_W), .SQ_DEPTH(SQ), .MAX_OUTSTANDING(MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .lq_valid(lq_valid), .lq_addr(lq_addr), .lq_id(lq_id),
        .lq_fn3(lq_fn3), .lq_store_mask(lq_store_mask), .lq_pop(lq_pop),
        .sq_pending(sq_pending), .flush(flush), .req(bus),
        .resp_ack(resp_ack), .outstanding(outstanding),
`ifdef LQ_ISSUE_STALL_CNT_EN
        .stall_cycles(stall_cycles), .dep_stall(dep_stall),
`endif
        .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit roll(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    // Monitor: every accepted request must be the oldest expected one.
    always @(negedge clk) begin
        if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
            if (exp_req.size() == 0) begin
                chk("unexpected_req", 1, 0);
            end else begin
                entry_t e;
                e = exp_req.pop_front();
                chk("req_addr", bus.req_addr, e.addr);
                chk("req_id",   bus.req_id,   e.id);
                chk("req_fn3",  bus.req_fn3,  e.fn3);
            end
        end
    end

    phase_t phases[8] = '{
        '{5,    100, 0,  0,  0,  100, 0},
        '{12,   100, 0,  0,  0,  0,   100},
        '{10,   100, 50, 0,  0,  0,   100},
        '{40,   40,  40, 0,  50, 0,   60},
        '{30,   70,  30, 15, 30, 0,   70},
        '{40,   60,  40, 5,  30, 3,   60},
        '{1500, 55,  45, 3,  35, 1,   55},
        '{80,   100, 80, 0,  0,  0,   0}
    };

    initial begin
        bit exp_pop, deps, hs, free_m, credit_m, exp_idle;
        rst = 1'b1; flush = 1'b0; resp_ack = 1'b0; bus.req_ready = 1'b0;
        lq_valid = 1'b0; lq_addr = '0; lq_id = '0; lq_fn3 = '0;
        lq_store_mask = '0; sq_pending = '0;
        slot_full = 1'b0; m_out = 0;
`ifdef LQ_ISSUE_STALL_CNT_EN
        m_stall = 0;
`endif
        foreach (phases[p]) begin
            for (int c = 0; c < phases[p].len; c++) begin
                @(posedge clk);
                #1;
                // refill the FIFO model
                if (fifo.size() < 8 && roll(phases[p].p_push)) begin
                    entry_t e;
                    e.addr = $urandom;
                    e.id   = ID_W'($urandom_range(0, 7));
                    e.fn3  = 3'($urandom_range(0, 7));
                    e.mask = roll(phases[p].p_dep) ? SQ'($urandom_range(0, 15)) : '0;
                    fifo.push_back(e);
                end
                rst           = roll(phases[p].p_rst);
                flush         = roll(phases[p].p_flush);
                bus.req_ready = roll(phases[p].p_ready);
                resp_ack      = (m_out > 0) && roll(phases[p].p_ack);
                sq_pending    = roll(phases[p].p_dep) ? SQ'($urandom_range(0, 15)) : '0;
                lq_valid      = (fifo.size() != 0);
                if (lq_valid) begin
                    lq_addr = fifo[0].addr; lq_id = fifo[0].id;
                    lq_fn3 = fifo[0].fn3; lq_store_mask = fifo[0].mask;
                end else begin
                    lq_addr = $urandom; lq_id = '0; lq_fn3 = '0;
                    lq_store_mask = SQ'($urandom_range(0, 15));
                end

                @(negedge clk);
                #1;
                deps     = (lq_store_mask & sq_pending) == '0;
                hs       = slot_full && bus.req_ready;
                free_m   = !slot_full || bus.req_ready;
                credit_m = (m_out + int'(slot_full)) < MAX;
                exp_pop  = !rst && lq_valid && (flush || (deps && free_m && credit_m));
                exp_idle = !slot_full && m_out == 0 && !lq_valid;

                chk("lq_pop",      lq_pop,        exp_pop);
                chk("req_valid",   bus.req_valid, slot_full);
                chk("outstanding", outstanding,   m_out);
                chk("idle",        idle,          exp_idle);
`ifdef LQ_ISSUE_STALL_CNT_EN
                chk("stall_cycles", stall_cycles, m_stall);
                chk("dep_stall",    dep_stall,    lq_valid && !deps);
                if (rst) m_stall = 0;
                else if (lq_valid && !flush && !exp_pop && m_stall < 65535) m_stall++;
`endif
                if (exp_pop) void'(fifo.pop_front());
                if (rst) begin
                    slot_full = 1'b0;
                    m_out = 0;
                    exp_req.delete();
                end else begin
                    m_out = m_out + int'(hs) - int'(resp_ack);
                    if (flush) begin
                        if (slot_full && !hs && exp_req.size() != 0)
                            void'(exp_req.pop_back());
                        slot_full = 1'b0;
                    end else if (exp_pop) begin
                        entry_t e;
                        e.addr = lq_addr; e.id = lq_id; e.fn3 = lq_fn3; e.mask = lq_store_mask;
                        exp_req.push_back(e);
                        slot_full = 1'b1;
                    end else if (hs) begin
                        slot_full = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0; flush = 1'b0; resp_ack = 1'b0;
        @(negedge clk);
        chk("final_idle",  idle,        1'b1);
        chk("final_count", outstanding, '0);
        chk("sb_empty",    exp_req.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
